// File: rtl/pio_master_bridge.sv
// Command-to-Avalon-MM bridge for a PIO slave: single write, single read,
// or masked poll with bounded retries. One command in flight at a time.
module pio_master_bridge #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [1:0]           cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [31:0]          cmd_mask,
  input  logic [TIMEOUT_W-1:0] cmd_timeout,
  output logic [1:0]           avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [31:0]          avm_writedata,
  input  logic [31:0]          avm_readdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [1:0]           rsp_status
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ILLEGAL = 2'b10;

  logic [2:0]           r_state;
  logic [1:0]           r_op;
  logic [1:0]           r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_mask;
  logic [TIMEOUT_W-1:0] r_count;
  logic [31:0]          r_rsp_data;
  logic [1:0]           r_rsp_status;

  logic                 w_match;

  // A zero mask makes both sides zero, so mask 0 matches on the first read.
  assign w_match = ((avm_readdata & r_mask) == (r_wdata & r_mask));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_op         <= OP_WRITE;
      r_addr       <= 2'b00;
      r_wdata      <= 32'h0;
      r_mask       <= 32'h0;
      r_count      <= '0;
      r_rsp_data   <= 32'h0;
      r_rsp_status <= ST_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_addr  <= cmd_addr;
            r_wdata <= cmd_wdata;
            r_mask  <= cmd_mask;
            r_count <= cmd_timeout;
            case (cmd_op)
              OP_WRITE: r_state <= S_WRITE;
              OP_READ,
              OP_POLL:  r_state <= S_READ;
              default: begin
                r_state      <= S_RESP;
                r_rsp_data   <= 32'h0;
                r_rsp_status <= ST_ILLEGAL;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_rsp_data   <= 32'h0;
          r_rsp_status <= ST_OK;
        end
        S_READ: begin
          r_state <= S_RWAIT;
        end
        S_RWAIT: begin
          // Slave data arrives one cycle after the READ strobe; capture it here.
          if (r_op == OP_READ || w_match) begin
            r_state      <= S_RESP;
            r_rsp_data   <= avm_readdata;
            r_rsp_status <= ST_OK;
          end else if (r_count == '0) begin
            r_state      <= S_RESP;
            r_rsp_data   <= avm_readdata;
            r_rsp_status <= ST_TIMEOUT;
          end else begin
            r_count <= r_count - 1'b1;
            r_state <= S_READ;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign avm_chipselect = (r_state == S_WRITE) || (r_state == S_READ);
  assign avm_write_n    = (r_state != S_WRITE);
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign rsp_valid      = (r_state == S_RESP);
  assign rsp_data       = r_rsp_data;
  assign rsp_status     = r_rsp_status;

endmodule

// File: tb/tb_pio_master_bridge.sv
// Directed bench for pio_master_bridge with a 1-cycle-latency PIO slave model.
`timescale 1ns/1ps
module tb_pio_master_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_addr = 2'b00;
  logic [31:0] cmd_wdata = 32'h0;
  logic [31:0] cmd_mask = 32'h0;
  logic [15:0] cmd_timeout = 16'h0;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;

  int n_checks = 0;
  int n_fail = 0;

  // slave model: reads numbered from 0; reads at or after rise_at return slave_after
  logic [31:0] slave_base = 32'h0;
  logic [31:0] slave_after = 32'h0;
  int          rise_at = 1000000;
  int          slave_reads = 0;
  int          wr_strobes = 0;
  logic [31:0] last_wdata = 32'h0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_val = 32'h0;

  always #5 clk = ~clk;

  pio_master_bridge #(.TIMEOUT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .cmd_timeout(cmd_timeout),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status)
  );

  always @(negedge clk) begin
    if (avm_chipselect === 1'b1 && avm_write_n === 1'b1) begin
      rd_val = (slave_reads >= rise_at) ? slave_after : slave_base;
      slave_reads = slave_reads + 1;
      rd_req = 1'b1;
    end else begin
      rd_req = 1'b0;
    end
    if (avm_write_n === 1'b0) begin
      wr_strobes = wr_strobes + 1;
      last_wdata = avm_writedata;
    end
  end

  always @(posedge clk) begin
    if (rd_req) avm_readdata <= rd_val;
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] mask,
                       input logic [15:0] tmo);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    cmd_wdata = wdata; cmd_mask = mask; cmd_timeout = tmo;
    @(negedge clk);
    // scramble the command bus to show the bridge kept its own copy
    cmd_valid = 1'b0; cmd_op = ~op; cmd_addr = ~addr;
    cmd_wdata = ~wdata; cmd_mask = ~mask; cmd_timeout = tmo + 16'd7;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs got=%0b exp=0", avm_chipselect); end
    n_checks++; if (avm_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_write_n got=%0b exp=1", avm_write_n); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%0b exp=1", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    n_checks++; if (avm_address !== 2'b00) begin n_fail++; $display("FAIL reset_address got=%0h exp=0", avm_address); end
    n_checks++; if (avm_writedata !== 32'h0) begin n_fail++; $display("FAIL reset_writedata got=%h exp=0", avm_writedata); end
    n_checks++; if (rsp_data !== 32'h0 || rsp_status !== 2'b00) begin n_fail++; $display("FAIL reset_rsp got=%h/%0b exp=0/00", rsp_data, rsp_status); end
    $display("test_reset done");
  endtask

  task automatic test_write();
    int lat; int w0; int r0;
    w0 = wr_strobes; r0 = slave_reads;
    issue(2'b00, 2'd3, 32'hDEADBEEF, 32'h0, 16'd0);
    n_checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b0) begin n_fail++; $display("FAIL write_strobe got cs=%0b wn=%0b exp cs=1 wn=0", avm_chipselect, avm_write_n); end
    n_checks++; if (avm_writedata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_data got=%h exp=deadbeef", avm_writedata); end
    n_checks++; if (avm_address !== 2'd3) begin n_fail++; $display("FAIL write_addr got=%0d exp=3", avm_address); end
    wait_rsp(lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL write_latency got=%0d exp=2", lat); end
    n_checks++; if (rsp_status !== 2'b00 || rsp_data !== 32'h0) begin n_fail++; $display("FAIL write_rsp got=%h/%0b exp=0/00", rsp_data, rsp_status); end
    n_checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_address !== 2'd3) begin n_fail++; $display("FAIL write_bus_idle got cs=%0b wn=%0b a=%0d exp 0/1/3", avm_chipselect, avm_write_n, avm_address); end
    consume();
    n_checks++; if (wr_strobes - w0 !== 1 || slave_reads - r0 !== 0) begin n_fail++; $display("FAIL write_strobe_count got w=%0d r=%0d exp w=1 r=0", wr_strobes - w0, slave_reads - r0); end
    $display("test_write: lat=%0d data=%h status=%0b", lat, last_wdata, rsp_status);
  endtask

  task automatic test_read();
    int lat; int r0;
    slave_base = 32'h12345678; rise_at = slave_reads + 1000;
    r0 = slave_reads;
    issue(2'b01, 2'd0, 32'h0, 32'h0, 16'd0);
    n_checks++; if (avm_chipselect !== 1'b1 || avm_write_n !== 1'b1) begin n_fail++; $display("FAIL read_strobe got cs=%0b wn=%0b exp cs=1 wn=1", avm_chipselect, avm_write_n); end
    wait_rsp(lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency got=%0d exp=3", lat); end
    n_checks++; if (rsp_data !== 32'h12345678 || rsp_status !== 2'b00) begin n_fail++; $display("FAIL read_rsp got=%h/%0b exp=12345678/00", rsp_data, rsp_status); end
    consume();
    n_checks++; if (slave_reads - r0 !== 1) begin n_fail++; $display("FAIL read_count got=%0d exp=1", slave_reads - r0); end
    $display("test_read: lat=%0d data=%h status=%0b", lat, rsp_data, rsp_status);
  endtask

  task automatic test_poll(input string name, input logic [31:0] base, input logic [31:0] after,
                           input int rise, input logic [31:0] wdata, input logic [31:0] mask,
                           input logic [15:0] tmo, input int exp_reads, input int exp_lat,
                           input logic [31:0] exp_data, input logic [1:0] exp_status);
    int lat; int r0;
    slave_base = base; slave_after = after;
    r0 = slave_reads; rise_at = slave_reads + rise;
    issue(2'b10, 2'd1, wdata, mask, tmo);
    wait_rsp(lat);
    n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
    n_checks++; if (rsp_data !== exp_data || rsp_status !== exp_status) begin n_fail++; $display("FAIL %s_rsp got=%h/%0b exp=%h/%0b", name, rsp_data, rsp_status, exp_data, exp_status); end
    n_checks++; if (slave_reads - r0 !== exp_reads) begin n_fail++; $display("FAIL %s_reads got=%0d exp=%0d", name, slave_reads - r0, exp_reads); end
    consume();
    $display("test_poll %s: lat=%0d reads=%0d data=%h status=%0b", name, lat, slave_reads - r0, rsp_data, rsp_status);
  endtask

  task automatic test_backpressure_illegal();
    int lat; int r0; int w0;
    r0 = slave_reads; w0 = wr_strobes;
    issue(2'b11, 2'd2, 32'h1, 32'h1, 16'd4);
    wait_rsp(lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_data !== 32'h0 || cmd_ready !== 1'b0 || avm_chipselect !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_hold cycle=%0d got v=%0b st=%0b d=%h rdy=%0b cs=%0b exp 1/10/0/0/0", i, rsp_valid, rsp_status, rsp_data, cmd_ready, avm_chipselect);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL consume_cmd_ready got=%0b exp=0", cmd_ready); end
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL after_consume got v=%0b rdy=%0b exp 0/1", rsp_valid, cmd_ready); end
    n_checks++; if (slave_reads - r0 !== 0 || wr_strobes - w0 !== 0) begin n_fail++; $display("FAIL illegal_bus got r=%0d w=%0d exp 0/0", slave_reads - r0, wr_strobes - w0); end
    $display("test_backpressure_illegal: lat=%0d", lat);
  endtask

  task automatic test_reset_mid_poll();
    int r0;
    slave_base = 32'h0; rise_at = slave_reads + 1000;
    issue(2'b10, 2'd2, 32'h1, 32'h1, 16'd5);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (avm_chipselect !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_imm got cs=%0b v=%0b exp 0/0", avm_chipselect, rsp_valid); end
    n_checks++; if (avm_address !== 2'b00 || avm_write_n !== 1'b1) begin n_fail++; $display("FAIL midreset_bus got a=%0d wn=%0b exp 0/1", avm_address, avm_write_n); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    r0 = slave_reads;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got rdy=%0b v=%0b exp 1/0", cmd_ready, rsp_valid); end
    repeat (6) @(negedge clk);
    n_checks++; if (slave_reads - r0 !== 0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet got reads=%0d v=%0b exp 0/0", slave_reads - r0, rsp_valid); end
    $display("test_reset_mid_poll done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_poll("poll_match",   32'h0,  32'h1, 2,    32'h1,  32'h1,  16'd5, 3, 7, 32'h1,  2'b00);
    test_poll("poll_timeout", 32'h0,  32'h0, 1000, 32'hAA, 32'hFF, 16'd3, 4, 9, 32'h0,  2'b01);
    test_poll("poll_mask0",   32'h55, 32'h0, 1000, 32'hAA, 32'h0,  16'd5, 1, 3, 32'h55, 2'b00);
    test_poll("poll_tmo0",    32'h0,  32'h0, 1000, 32'hAA, 32'hFF, 16'd0, 1, 3, 32'h0,  2'b01);
    test_backpressure_illegal();
    test_reset_mid_poll();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
